// File: rtl/sample_fsm_pkg.sv
// Shared types and constants for the sample_fsm pulse timer.
package sample_fsm_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_t;

  localparam int unsigned ON_CYCLES_DEF = 3;

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sample_fsm_counter.sv
// Up-counter with synchronous clear; clear wins over increment.
module sample_fsm_counter #(
  parameter int unsigned W = 2
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_clr)
      r_cnt <= '0;
    else if (i_inc)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/sample_fsm.sv
// Moore pulse stretcher: a sampled press on B holds X high
// for exactly ON_CYCLES clocks, then forces one idle cycle.
module sample_fsm
  import sample_fsm_pkg::*;
#(
  parameter int unsigned ON_CYCLES = ON_CYCLES_DEF
) (
  input  logic B,
  output logic X,
  input  logic Clk,
  input  logic Rst
);

  localparam int unsigned W = cnt_w(ON_CYCLES);
  localparam logic [W-1:0] LP_LAST = W'(ON_CYCLES);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] w_cnt;
  logic         w_clr;
  logic         w_inc;
  logic         w_x_nxt;
  logic         r_x;

  always_ff @(posedge Clk) begin
    if (Rst)
      r_state <= ST_OFF;
    else
      r_state <= w_state_nxt;
  end

  // cnt is held at 0 in OFF, so entering ON via inc lands on 1
  always_comb begin
    w_state_nxt = ST_OFF;
    w_clr       = 1'b1;
    w_inc       = 1'b0;
    case (r_state)
      ST_OFF: begin
        if (B) begin
          w_state_nxt = ST_ON;
          w_clr       = 1'b0;
          w_inc       = 1'b1;
        end
      end
      ST_ON: begin
        if (w_cnt != LP_LAST) begin
          w_state_nxt = ST_ON;
          w_clr       = 1'b0;
          w_inc       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  always_comb begin
    w_x_nxt = (w_state_nxt == ST_ON);
  end

  always_ff @(posedge Clk) begin
    if (Rst)
      r_x <= 1'b0;
    else
      r_x <= w_x_nxt;
  end

  sample_fsm_counter #(
    .W(W)
  ) u_cnt (
    .i_clk(Clk),
    .i_clr(Rst | w_clr),
    .i_inc(w_inc),
    .o_cnt(w_cnt)
  );

  assign X = r_x;

endmodule

// File: tb/tb_sample_fsm.sv
// Scoreboard bench: three builds (ON_CYCLES 3, 1, 5) share B/Rst
// and are checked edge by edge against hand-computed X values.
module tb_sample_fsm;

  logic Clk;
  logic Rst;
  logic B;
  logic x3;
  logic x1;
  logic x5;

  typedef struct packed {
    logic e3;
    logic e1;
    logic e5;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_bad;

  localparam int NV = 34;
  // {Rst, B, X(N=3), X(N=1), X(N=5)} per rising edge
  logic [4:0] vecs [NV];

  sample_fsm #(.ON_CYCLES(3)) u_n3 (
    .B(B), .X(x3), .Clk(Clk), .Rst(Rst)
  );
  sample_fsm #(.ON_CYCLES(1)) u_n1 (
    .B(B), .X(x1), .Clk(Clk), .Rst(Rst)
  );
  sample_fsm #(.ON_CYCLES(5)) u_n5 (
    .B(B), .X(x5), .Clk(Clk), .Rst(Rst)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string nm, input int idx,
                     input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s edge %0d: got %b want %b",
               nm, idx, got, want);
    end
  endtask

  int edge_no;
  initial edge_no = 0;

  always @(posedge Clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("x_n3", edge_no, x3, e.e3);
      chk("x_n1", edge_no, x1, e.e1);
      chk("x_n5", edge_no, x5, e.e5);
      edge_no++;
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    vecs = '{
      5'b10000, 5'b00000, 5'b01111, 5'b00101,
      5'b00101, 5'b00001, 5'b00001, 5'b00000,
      5'b00000,
      5'b01111, 5'b01101, 5'b01111, 5'b00001,
      5'b00001, 5'b00000,
      5'b10000, 5'b00000, 5'b00000,
      5'b01111, 5'b01101, 5'b01111, 5'b01001,
      5'b01111, 5'b01100, 5'b01111, 5'b01001,
      5'b01111, 5'b01101,
      5'b11000, 5'b00000,
      5'b01111, 5'b10000, 5'b00000, 5'b00000
    };
    Rst = 1'b1;
    B   = 1'b0;
    for (int i = 0; i < NV; i++) begin
      logic [4:0] v;
      exp_t e;
      v    = vecs[i];
      Rst  = v[4];
      B    = v[3];
      e.e3 = v[2];
      e.e1 = v[1];
      e.e5 = v[0];
      q.push_back(e);
      @(negedge Clk);
    end
    Rst = 1'b0;
    B   = 1'b0;
    for (int k = 0; k < 4 && q.size() > 0; k++)
      @(negedge Clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sample_fsm.md
Name: sample_fsm

Overview:
- Single-input pulse-stretcher ("timer") Moore FSM.
- When button input B is sampled high in the idle state, output X is driven high for exactly ON_CYCLES consecutive clock cycles, then returns low.
- Serves as a small control block, for example a laser or lamp timer, that turns a button press into a fixed-width enable pulse.
- Positional port order is B, X, Clk, Rst, and existing instantiations connect by position.

Parameters:
- ON_CYCLES, default 3: number of clock cycles X stays high per trigger. Legal range is 1 to 255.

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Rst  input  1  reset, synchronous and active-high. Sampled only on the rising edge of Clk.
- B    input  1  trigger/button. Level-sampled on the rising edge of Clk.
- X    output 1  pulse output. Registered Moore output; a function of state only.

Behaviour:
- One clock (Clk). Reset Rst is synchronous and active-high.
- States:
  - OFF: idle, X=0.
  - ON: active, X=1, with an internal cycle counter cnt of width clog2(ON_CYCLES+1).
  - The ON_CYCLES=3 build is equivalent to a four-state machine: OFF, ON1, ON2, ON3.
- Reset:
  - Any rising edge with Rst=1 forces state OFF, cnt=0 and X=0.
  - Rst has priority over B and over any ON progress.
  - Before the first reset edge, X is undefined.
- Transitions, evaluated at each rising edge with Rst=0:
  - OFF, B=0: stay OFF.
  - OFF, B=1: go to ON with cnt=1. X=1 from this edge.
  - ON, cnt<ON_CYCLES: cnt increments; stay ON. B is ignored, so there is no retrigger or extension.
  - ON, cnt==ON_CYCLES: go to OFF with cnt=0. X=0 from this edge, regardless of B.
- Latency: X rises at the first rising edge where B=1 is sampled in OFF. There is no combinational path from B to X.
- Pulse width is exactly ON_CYCLES clock periods.
- B held high continuously gives a periodic waveform: ON_CYCLES cycles high, 1 cycle low, and so on. The OFF state always lasts at least one cycle.
- A B pulse shorter than a clock period that misses a rising edge has no effect.
- Reset mid-pulse: X=0 at the reset edge. Afterwards the FSM restarts from OFF, and B is re-evaluated on the following edges.
- Rst and B both high at the same edge: the result is OFF.
- Illegal or unreachable encodings recover to OFF on the next edge. The case statement has a default branch.
- All outputs come directly from flops. No latches.

Decomposition:
- Shared package sample_fsm_pkg:
  - state enum typedef (OFF, ON).
  - default ON_CYCLES constant.
  - a counter-width function (clog2).
- The single module contains a state register, next-state logic, a counter, and an output register.
- A sub-module is optional: sample_fsm_counter, a parameterized up-counter with synchronous clear. Inline logic is acceptable.

Test Plan:
- Reset: Rst=1 for one edge with B=0, then Rst=0 and B=0 for 2 edges -> X=0 throughout, state OFF.
- Single press with a 20 ns clock, reset released at 15 ns, and B=1 only across the edge at 50 ns -> X=1 on edges at 50, 70 and 90 ns. X=0 from the edge at 110 ns and stays 0 at 130 ns.
- Press ignored while active: B=1 at the first edge, then B=1 again on the 2nd and 3rd ON edges -> X is high for exactly 3 cycles, then OFF for at least 1 cycle.
- B held high for 10 edges after reset -> X sequence 1,1,1,0,1,1,1,0,1,1.
- Reset mid-pulse: trigger, then Rst=1 on the 2nd ON edge -> X=0 at that edge, and X stays 0 with B=0.
- Parameter check with ON_CYCLES=1 and a single press -> X=1 for exactly one cycle. With ON_CYCLES=5 -> exactly 5 cycles.
